// File: rtl/if_inst_queue.sv
// if_inst_queue: fetch-to-decode {pc, inst} FIFO with one-cycle flush.
// Optional zero-latency empty-queue bypass when IFQ_BYPASS_EN is defined.
module if_inst_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic [63:0]   i_pc,
  input  logic [31:0]   i_inst,
  output logic          o_ready,
  input  logic          i_flush,
  output logic          o_valid,
  output logic [63:0]   o_pc,
  output logic [31:0]   o_inst,
  input  logic          i_ready,
  output logic [AW:0]   o_count
);
  logic [95:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, empty, byp, push, pop;
  logic [95:0] head;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
`ifdef IFQ_BYPASS_EN
  assign byp = empty && i_valid && !i_flush;
`else
  assign byp = 1'b0;
`endif
  assign o_ready = !full && !i_flush;
  assign o_valid = (!empty || byp) && !i_flush;
  assign head = byp ? {i_pc, i_inst} : mem[rd_ptr[AW-1:0]];
  assign {o_pc, o_inst} = o_valid ? head : 96'd0;
  // a bypassed entry taken by decode the same cycle never touches storage
  assign push = i_valid && o_ready && !(byp && i_ready);
  assign pop = o_valid && i_ready && !byp;
  assign o_count = wr_ptr - rd_ptr;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk)
    if (push && !rst) mem[wr_ptr[AW-1:0]] <= {i_pc, i_inst};
endmodule

// File: tb/tb_if_inst_queue.sv
// tb_if_inst_queue: directed scenarios plus randomized run against a queue model.
module tb_if_inst_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst, i_valid, i_flush, i_ready, o_ready, o_valid;
  logic [63:0] i_pc, o_pc;
  logic [31:0] i_inst, o_inst;
  logic [2:0] o_count;
  int tests = 0, fails = 0;
  if_inst_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_pc(i_pc), .i_inst(i_inst),
    .o_ready(o_ready), .i_flush(i_flush), .o_valid(o_valid), .o_pc(o_pc),
    .o_inst(o_inst), .i_ready(i_ready), .o_count(o_count)
  );
  always #5 clk = ~clk;
  task automatic set(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                     input logic f, input logic r);
    i_valid = v; i_pc = pc; i_inst = inst; i_flush = f; i_ready = r;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    set(0, 0, 0, 1, 0);
    tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL reset_flush_ready got %0b want 0", o_ready); end
    tick();
    set(1, 64'h1234, 32'h55, 0, 0);
    tick();
    set(0, 0, 0, 0, 0);
    tick();
    rst = 0;
    #1;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", o_valid); end
    tests++; if (o_pc !== 64'd0) begin fails++; $display("FAIL reset_pc got %h want 0", o_pc); end
    tests++; if (o_inst !== 32'd0) begin fails++; $display("FAIL reset_inst got %h want 0", o_inst); end
    tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", o_count); end
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b want 1", o_ready); end
  endtask
  task automatic test_single();
    set(1, 64'h80000000, 32'h13, 0, 1);
`ifdef IFQ_BYPASS_EN
    tests++; if (o_valid !== 1'b1 || o_pc !== 64'h80000000) begin fails++; $display("FAIL single_byp got v=%0b pc=%h want 1 80000000", o_valid, o_pc); end
    tick();
    set(0, 0, 0, 0, 1);
`else
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL single_lat got %0b want 0", o_valid); end
    tick();
    set(0, 0, 0, 0, 1);
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %0b want 1", o_valid); end
    tests++; if (o_pc !== 64'h80000000) begin fails++; $display("FAIL single_pc got %h want 80000000", o_pc); end
    tests++; if (o_inst !== 32'h13) begin fails++; $display("FAIL single_inst got %h want 13", o_inst); end
    tick();
`endif
    tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL single_count got %0d want 0", o_count); end
  endtask
  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      set(1, 64'h80000000 + 64'(4*i), 32'(i), 0, 0);
      if (i == 4) begin
        tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL fill_ready got %0b want 0", o_ready); end
      end
      tick();
    end
    set(0, 0, 0, 0, 0);
    tests++; if (o_count !== 3'd4) begin fails++; $display("FAIL fill_count got %0d want 4", o_count); end
    for (int i = 0; i < 4; i++) begin
      set(0, 0, 0, 0, 1);
      tests++; if (o_valid !== 1'b1 || o_pc !== 64'h80000000 + 64'(4*i)) begin fails++; $display("FAIL fill_pop%0d got v=%0b pc=%h want %h", i, o_valid, o_pc, 64'h80000000 + 64'(4*i)); end
      tick();
    end
    set(0, 0, 0, 0, 0);
    tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL fill_drain got %0d want 0", o_count); end
  endtask
  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) begin
      set(1, 64'h90000000 + 64'(4*i), 32'(i), 0, 0);
      tick();
    end
    set(1, 64'hA0000000, 32'h77, 0, 1);
    tests++; if (o_ready !== 1'b0 || o_pc !== 64'h90000000) begin fails++; $display("FAIL full_pp got rdy=%0b pc=%h want 0 90000000", o_ready, o_pc); end
    tick();
    set(0, 0, 0, 0, 0);
    tests++; if (o_count !== 3'd3) begin fails++; $display("FAIL full_pp_count got %0d want 3", o_count); end
    tests++; if (o_ready !== 1'b1) begin fails++; $display("FAIL full_pp_ready got %0b want 1", o_ready); end
    tests++; if (o_pc !== 64'h90000004) begin fails++; $display("FAIL full_pp_head got %h want 90000004", o_pc); end
    set(0, 0, 0, 1, 0);
    tick();
  endtask
  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set(1, 64'hB0000000 + 64'(4*i), 32'(i), 0, 0);
      tick();
    end
    set(1, 64'hC0000000, 32'h1, 1, 1);
    tests++; if (o_valid !== 1'b0 || o_ready !== 1'b0) begin fails++; $display("FAIL flush_cycle got v=%0b rdy=%0b want 0 0", o_valid, o_ready); end
    tick();
    set(0, 0, 0, 0, 0);
    tests++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin fails++; $display("FAIL flush_after got cnt=%0d v=%0b want 0 0", o_count, o_valid); end
    set(1, 64'h80001000, 32'h2, 0, 0);
    tick();
    set(0, 0, 0, 0, 0);
    tests++; if (o_valid !== 1'b1 || o_pc !== 64'h80001000) begin fails++; $display("FAIL flush_repush got v=%0b pc=%h want 1 80001000", o_valid, o_pc); end
    set(0, 0, 0, 1, 0);
    tick();
  endtask
  task automatic test_wrap();
    logic [63:0] seen [$];
    for (int i = 0; i < 22; i++) begin
      set(i < 20, 64'hD0000000 + 64'(4*i), 32'(i), 0, 1);
      if (o_valid) seen.push_back(o_pc);
      tests++; if (o_count > 3'd1) begin fails++; $display("FAIL wrap_count cycle %0d got %0d want <=1", i, o_count); end
      tick();
    end
    tests++; if (seen.size() != 20) begin fails++; $display("FAIL wrap_len got %0d want 20", seen.size()); end
    for (int i = 0; i < seen.size() && i < 20; i++) begin
      tests++; if (seen[i] !== 64'hD0000000 + 64'(4*i)) begin fails++; $display("FAIL wrap_seq%0d got %h want %h", i, seen[i], 64'hD0000000 + 64'(4*i)); end
    end
  endtask
  task automatic test_bypass();
    set(1, 64'h80000020, 32'h33, 0, 1);
`ifdef IFQ_BYPASS_EN
    tests++; if (o_valid !== 1'b1 || o_pc !== 64'h80000020) begin fails++; $display("FAIL byp_same got v=%0b pc=%h want 1 80000020", o_valid, o_pc); end
    tick();
    set(0, 0, 0, 0, 1);
    tests++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin fails++; $display("FAIL byp_after got cnt=%0d v=%0b want 0 0", o_count, o_valid); end
`else
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL byp_off_same got %0b want 0", o_valid); end
    tick();
    set(0, 0, 0, 0, 1);
    tests++; if (o_valid !== 1'b1 || o_pc !== 64'h80000020) begin fails++; $display("FAIL byp_off_next got v=%0b pc=%h want 1 80000020", o_valid, o_pc); end
    tick();
    tests++; if (o_count !== 3'd0) begin fails++; $display("FAIL byp_off_count got %0d want 0", o_count); end
`endif
  endtask
  task automatic test_random();
    logic [95:0] q [$];
    logic v, f, r, by, ev, er;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [95:0] eh;
    for (int c = 0; c < 400; c++) begin
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 2) != 0;
      f = $urandom_range(0, 15) == 0;
      pc = {$urandom, $urandom};
      inst = $urandom;
      rst = $urandom_range(0, 63) == 0;
      set(v, pc, inst, f, r);
`ifdef IFQ_BYPASS_EN
      by = q.size() == 0 && v && !f;
`else
      by = 0;
`endif
      er = q.size() < DEPTH && !f;
      ev = !f && (q.size() > 0 || by);
      eh = !ev ? 96'd0 : (q.size() > 0 ? q[0] : {pc, inst});
      tests++; if (o_ready !== er) begin fails++; $display("FAIL rnd_ready c%0d got %0b want %0b", c, o_ready, er); end
      tests++; if (o_valid !== ev) begin fails++; $display("FAIL rnd_valid c%0d got %0b want %0b", c, o_valid, ev); end
      tests++; if ({o_pc, o_inst} !== eh) begin fails++; $display("FAIL rnd_head c%0d got %h want %h", c, {o_pc, o_inst}, eh); end
      tests++; if (o_count !== 3'(q.size())) begin fails++; $display("FAIL rnd_count c%0d got %0d want %0d", c, o_count, q.size()); end
      tick();
      if (rst || f) q.delete();
      else if (!(by && r)) begin
        if (ev && r) void'(q.pop_front());
        if (v && er) q.push_back({pc, inst});
      end
    end
    rst = 0;
  endtask
  initial begin
    rst = 0;
    set(0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_fill();
    test_full_pushpop();
    test_flush();
    test_wrap();
    test_bypass();
    set(0, 0, 0, 1, 0);
    tick();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
